mem_access_ctrl: RTL and testbench

- Controller that sequences the MEM stage of the 5-stage MIPS pipeline against a variable-latency data memory using a req/ack handshake.
- Sits directly downstream of the EX/MEM pipeline register.
- Issues exactly one memory transaction per load/store held in MEM, returns load data, and asserts StallM to freeze the front of the pipeline until the access completes.

---
 rtl/mips_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_access_ctrl.sv | 89 ++++++++
 tb/tb_mem_access_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage controller
// state encoding, bus widths and the bus-error fill pattern.
package mips_pkg;

  localparam int MIPS_AW = 32;
  localparam int MIPS_DW = 32;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memState_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// REQ-phase watchdog for the MEM-stage controller.
// Compiled only when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic ack,
  output logic expired
);

  logic [7:0] cnt;

  // Leaving REQ clears the count, so every entry starts at zero
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (!ack) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = run & ~ack & (cnt == 8'(LIMIT));

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one req/ack transaction per load/store.
// Optional REQ watchdog with bus error under MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int AW             = MIPS_AW,
  parameter int DW             = MIPS_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemtoRegM,
  input  logic          FlushM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] WriteDataM,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRdata,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  output logic          StallM,
  output logic [DW-1:0] ReadDataM,
  output logic          BusErrM
);

  memState_t state, stateNext;
  logic      access;
  logic      timeout;

  assign access = (MemWriteM | MemtoRegM) & ~FlushM;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .reset  (reset),
    .run    (state == REQ),
    .ack    (MemAck),
    .expired(timeout)
  );
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (access) stateNext = REQ;
      REQ:  if (MemAck || timeout) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWdata  <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      state   <= stateNext;
      BusErrM <= 1'b0;
      if (state == IDLE && access) begin
        MemAddr  <= ALUOutM;
        MemWdata <= WriteDataM;
        MemWe    <= MemWriteM;
      end
      // Ack beats a simultaneous timeout
      if (state == REQ && MemAck) begin
        if (!MemWe) ReadDataM <= MemRdata;
      end else if (state == REQ && timeout) begin
        ReadDataM <= DW'(BUS_ERR_DATA);
        BusErrM   <= 1'b1;
      end
    end
  end

  assign MemReq = (state == REQ);
  assign StallM = (state == IDLE && access) || (state == REQ);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a
// transaction-level model of the MEM-stage handshake.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM, FlushM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        MemAck;
  logic [31:0] MemRdata;
  logic        MemReq, MemWe, StallM, BusErrM;
  logic [31:0] MemAddr, MemWdata, ReadDataM;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expRd;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .MemtoRegM (MemtoRegM),
    .FlushM    (FlushM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .MemAck    (MemAck),
    .MemRdata  (MemRdata),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWdata  (MemWdata),
    .StallM    (StallM),
    .ReadDataM (ReadDataM),
    .BusErrM   (BusErrM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One load/store held in MEM; ack k cycles after MemReq rises
  task automatic doAccess(input bit we, input bit rd,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input logic [31:0] rdata,
                          input int k);
    int  stalls;
    int  rises;
    bit  prevReq;
    stalls  = 0;
    rises   = 0;
    prevReq = 1'b0;
    MemWriteM  = we;
    MemtoRegM  = rd;
    FlushM     = 1'b0;
    ALUOutM    = addr;
    WriteDataM = wdata;
    for (int c = 0; c < k + 3; c++) begin
      if (c == k + 1) begin
        MemAck   = 1'b1;
        MemRdata = rdata;
      end else begin
        MemAck   = (c == k + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        MemRdata = $urandom;
      end
      @(negedge clk);
      stalls += int'(StallM);
      if (MemReq && !prevReq) rises++;
      prevReq = MemReq;
      if (c >= 1 && c <= k + 1) begin
        check("reqHigh", 32'(MemReq), 32'd1);
        check("addr", MemAddr, addr);
        check("we", 32'(MemWe), 32'(we));
        check("wdata", MemWdata, wdata);
      end else begin
        check("reqLow", 32'(MemReq), 32'd0);
      end
      if (c == k + 2 && rd && !we) expRd = rdata;
      check("rdata", ReadDataM, expRd);
      check("busErr", 32'(BusErrM), 32'd0);
      nextCycle();
    end
    check("stallCnt", 32'(stalls), 32'(k + 2));
    check("reqRises", 32'(rises), 32'd1);
  endtask

  // A cycle with nothing to do in MEM (or a flushed access)
  task automatic doIdle(input bit flushed, input bit spur);
    MemWriteM  = flushed ? 1'($urandom_range(0, 1)) : 1'b0;
    MemtoRegM  = flushed ? ~MemWriteM | 1'($urandom_range(0, 1)) : 1'b0;
    FlushM     = flushed ? 1'b1 : 1'($urandom_range(0, 1));
    ALUOutM    = $urandom;
    WriteDataM = $urandom;
    MemAck     = spur;
    MemRdata   = $urandom;
    @(negedge clk);
    check("idleStall", 32'(StallM), 32'd0);
    check("idleReq", 32'(MemReq), 32'd0);
    check("idleRdata", ReadDataM, expRd);
    nextCycle();
  endtask

  initial begin
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    FlushM     = 1'b0;
    ALUOutM    = '0;
    WriteDataM = '0;
    MemAck     = 1'b0;
    MemRdata   = '0;
    expRd      = '0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    check("rstReq", 32'(MemReq), 32'd0);
    check("rstStall", 32'(StallM), 32'd0);
    check("rstAddr", MemAddr, 32'd0);
    check("rstWdata", MemWdata, 32'd0);
    check("rstWe", 32'(MemWe), 32'd0);
    check("rstRdata", ReadDataM, 32'd0);
    check("rstBusErr", 32'(BusErrM), 32'd0);
    nextCycle();
    reset = 1'b0;

    doAccess(1'b0, 1'b1, 32'h10, 32'h0, 32'h12345678, 3);
    doAccess(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    doAccess(1'b0, 1'b1, 32'h30, 32'h0, 32'hA5A5_0001, 1);
    doAccess(1'b1, 1'b0, 32'h34, 32'h1111_2222, 32'h0, 2);
    doIdle(1'b0, 1'b1);
    doIdle(1'b1, 1'b0);
    doAccess(1'b1, 1'b1, 32'h40, 32'h7777_8888, 32'hBAD0_BAD0, 1);

    // Reset during the second REQ cycle abandons the access
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b1;
    ALUOutM    = 32'h50;
    MemAck     = 1'b0;
    nextCycle();
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    check("rstMidReq", 32'(MemReq), 32'd1);
    nextCycle();
    reset     = 1'b0;
    MemtoRegM = 1'b0;
    expRd     = '0;
    @(negedge clk);
    check("abortReq", 32'(MemReq), 32'd0);
    check("abortStall", 32'(StallM), 32'd0);
    check("abortAddr", MemAddr, 32'd0);
    check("abortWe", 32'(MemWe), 32'd0);
    check("abortRdata", ReadDataM, 32'd0);
    nextCycle();

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        doIdle(1'(sel), 1'($urandom_range(0, 1)));
      end else begin
        doAccess(sel == 9 || sel < 5,
                 sel >= 5,
                 $urandom, $urandom, $urandom,
                 $urandom_range(0, 6));
      end
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int pulses;
      pulses    = 0;
      MemWriteM = 1'b0;
      MemtoRegM = 1'b1;
      FlushM    = 1'b0;
      MemAck    = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (BusErrM) begin
          pulses++;
          check("toData", ReadDataM, 32'hDEADBEEF);
          MemtoRegM = 1'b0;
        end
        nextCycle();
      end
      check("toPulses", 32'(pulses), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
